muldiv_iter: RTL and testbench
==============================

Name: muldiv_iter

Overview:
- Iterative RV32M multiply/divide execution unit with start/done handshake.
- Sits beside the integer ALU in the multicycle/pipelined datapath; the datapath freezes PC and register write while oBusy is high.
- Parametrised in operand width and radix (bits retired per cycle).
- Provides MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, which the single-cycle ALU does not.

Parameters:
- XLEN, 32, operand/result width; must be even, at least 8.
- STEP, 1, bits processed per iteration (1 or 2); XLEN must be divisible by STEP; N = XLEN/STEP iterations.

Ports:
- iCLK  input  1  clock; all state changes on the rising edge.
- iRST  input  1  reset, synchronous and active-high.
- iStart  input  1  request; sampled only in IDLE.
- iFunct3  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- iA  input  XLEN  rs1 operand.
- iB  input  XLEN  rs2 operand.
- oBusy  output  1  high from the accepting edge until the edge that raises oDone.
- oDone  output  1  single-cycle pulse; oResult is valid in that cycle.
- oResult  output  XLEN  result register; holds until the next completion.

Behaviour:
- Reset: iRST high at a rising edge forces state IDLE, oBusy=0, oDone=0, oResult=0 and clears all internal registers. This applies mid-operation and aborts it with no oDone.
- States: IDLE, PREP, ITER, FIX.
- IDLE: iStart=1 at an edge latches iA, iB and iFunct3, then goes to PREP. oBusy rises and oDone clears at the same edge. iStart in any other state is ignored; operand changes after acceptance are ignored.
- PREP (one cycle): compute magnitudes and the result sign per op.
  - MULH, DIV, REM: both operands signed.
  - MULHSU: iA signed, iB unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - MUL: low word is sign-independent.
  - Clear the 2*XLEN accumulator and the counter; go to ITER.
  - Special cases skip ITER and go straight to FIX with a forced result:
    - divide by zero: DIV/DIVU give all-ones; REM/REMU give the dividend.
    - signed overflow (DIV/REM with iA = 1 followed by XLEN-1 zeros, iB = all-ones): DIV gives the dividend; REM gives 0.
- ITER (N cycles, counter 0..N-1): each cycle retires STEP bits.
  - Multiply: shift-add on the 2*XLEN product.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - When counter = N-1, go to FIX.
- FIX (one cycle): apply sign correction (two's complement negate when the result sign is negative) and select the result.
  - MUL: low XLEN bits.
  - MULH*: high XLEN bits.
  - DIV*: quotient.
  - REM*: remainder, which takes the sign of the dividend.
  - At the exit edge: write oResult, set oDone=1 for one cycle, clear oBusy, return to IDLE.
- Latency, measured in edges from the accepting edge to the edge raising oDone:
  - normal: N+2 (34 for XLEN=32, STEP=1; 18 for STEP=2).
  - special cases: 2.
- Back-to-back: iStart=1 during the oDone cycle is accepted. oDone falls and oBusy rises at the same edge; the new op proceeds normally.
- All arithmetic is modulo 2^XLEN on results; intermediate products use the full 2*XLEN width with no truncation.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: multiply ops (funct3 0xx) compute the full 2*XLEN product combinationally in PREP from the sign-extended operands and go straight to FIX. Multiply latency is 2; divide behaviour is unchanged.
- Undefined: multiplies use the iterative ITER path with latency N+2, and no hardware multiplier is inferred.

Test Plan:
- MUL, iA=7, iB=-3 (0xFFFFFFFD), XLEN=32, STEP=1 -> oDone exactly 34 edges after acceptance; oResult=0xFFFFFFEB; oBusy high for those 34 cycles.
- MULH/MULHSU/MULHU with iA=0x80000000, iB=0xFFFFFFFF -> 0x00000000 / 0x80000000 / 0x7FFFFFFF respectively.
- DIV iA=-7, iB=2 -> 0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1); DIVU iA=100, iB=7 -> 14; REMU -> 2.
- Divide by zero: DIV iA=5, iB=0 -> 0xFFFFFFFF after 2 edges; REMU iA=5, iB=0 -> 5. Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- iRST pulsed at ITER counter=10 -> next cycle oBusy=0, oDone=0, oResult=0, and no oDone afterwards. A new iStart for DIVU 9/3 then returns 3.
- Back-to-back: iStart held high across oDone of DIVU 9/3 with the next op MUL 6*7 -> second oDone yields 42. STEP=2 run of the same -> latency 18. With MULDIV_FAST_MUL_EN defined, MUL 6*7 -> latency 2.

Source files
------------

// File: rtl/muldiv_iter_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// Ports: iStart/iFunct3/iA/iB (request, master -> slave), oBusy/oDone/oResult (status, slave -> master).
// Parameter XLEN sets operand and result width; it must match the attached unit.
interface muldiv_iter_if #(
    parameter int XLEN = 32
);
    logic            iStart;
    logic [2:0]      iFunct3;
    logic [XLEN-1:0] iA;
    logic [XLEN-1:0] iB;
    logic            oBusy;
    logic            oDone;
    logic [XLEN-1:0] oResult;

    modport master (
        output iStart, iFunct3, iA, iB,
        input  oBusy, oDone, oResult
    );

    modport slave (
        input  iStart, iFunct3, iA, iB,
        output oBusy, oDone, oResult
    );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU unit, STEP bits retired per cycle.
// Latency: N+2 edges (N = XLEN/STEP) from acceptance to oDone; 2 for divide-by-zero/overflow.
// Backpressure: iStart is only sampled in IDLE; oBusy is high while an op is in flight.
// Ports: iCLK, iRST (synchronous, active-high), bus (muldiv_iter_if.slave).
// Optional macro MULDIV_FAST_MUL_EN: multiplies use a combinational 2*XLEN product in PREP (latency 2).
module muldiv_iter #(
    parameter int XLEN = 32,
    parameter int STEP = 1
) (
    input  logic          iCLK,
    input  logic          iRST,
    muldiv_iter_if.slave  bus
);
    localparam int N  = XLEN / STEP;
    localparam int CW = $clog2(N + 1);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

    state_t            state_q, state_d;
    logic [2:0]        funct_q, funct_d;
    logic [XLEN-1:0]   a_q, a_d;     // raw rs1, then |rs1| (multiplicand / dividend shifter)
    logic [XLEN-1:0]   b_q, b_d;     // raw rs2, then |rs2| (multiplier shifter / divisor)
    logic [2*XLEN-1:0] acc_q, acc_d; // mul: product; div: {remainder, quotient}
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              neg_q, neg_d; // selected result must be negated in FIX
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   res_q, res_d;

    // combinational temporaries
    logic              signed_a, signed_b, a_sgn, b_sgn, qbit;
    logic [XLEN-1:0]   a_mag, b_mag, a_t, b_t;
    logic [2*XLEN-1:0] acc_t, fix_t;
    logic [XLEN:0]     sum_t, rem_t;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] prod_t;
`endif

    always_comb begin
        state_d  = state_q;
        funct_d  = funct_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        res_d    = res_q;

        signed_a = (funct_q == 3'b001) || (funct_q == 3'b010) ||
                   (funct_q == 3'b100) || (funct_q == 3'b110);
        signed_b = (funct_q == 3'b001) || (funct_q == 3'b100) || (funct_q == 3'b110);
        a_sgn    = signed_a & a_q[XLEN-1];
        b_sgn    = signed_b & b_q[XLEN-1];
        a_mag    = a_sgn ? (~a_q + 1'b1) : a_q;
        b_mag    = b_sgn ? (~b_q + 1'b1) : b_q;
        a_t      = a_q;
        b_t      = b_q;
        acc_t    = acc_q;
        sum_t    = '0;
        rem_t    = '0;
        qbit     = 1'b0;
        fix_t    = '0;
`ifdef MULDIV_FAST_MUL_EN
        prod_t   = {{XLEN{a_sgn}}, a_q} * {{XLEN{b_sgn}}, b_q};
`endif

        case (state_q)
            IDLE: begin
                if (bus.iStart) begin
                    a_d     = bus.iA;
                    b_d     = bus.iB;
                    funct_d = bus.iFunct3;
                    busy_d  = 1'b1;
                    state_d = PREP;
                end
            end

            PREP: begin
                a_d     = a_mag;
                b_d     = b_mag;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = ITER;
                // quotient sign is sa^sb, remainder follows the dividend; MUL is unsigned so 0
                if (funct_q[2])
                    neg_d = funct_q[1] ? a_sgn : (a_sgn ^ b_sgn);
                else
                    neg_d = a_sgn ^ b_sgn;

                // Forced results are placed in the half that FIX selects, with no negation:
                // quotient lives in the low half, remainder in the high half.
                if (funct_q[2] && (b_q == '0)) begin
                    neg_d   = 1'b0;
                    acc_d   = funct_q[1] ? {a_q, {XLEN{1'b0}}} : {{XLEN{1'b0}}, {XLEN{1'b1}}};
                    state_d = FIX;
                end else if (funct_q[2] && !funct_q[0] && (a_q == SMIN) && (b_q == '1)) begin
                    neg_d   = 1'b0;
                    acc_d   = funct_q[1] ? '0 : {{XLEN{1'b0}}, a_q};
                    state_d = FIX;
                end
`ifdef MULDIV_FAST_MUL_EN
                else if (!funct_q[2]) begin
                    neg_d   = 1'b0;
                    acc_d   = prod_t;
                    state_d = FIX;
                end
`endif
            end

            ITER: begin
                for (int s = 0; s < STEP; s++) begin
                    if (!funct_q[2]) begin
                        // shift-add: add multiplicand into the high half, shift product right
                        sum_t = {1'b0, acc_t[2*XLEN-1:XLEN]} + (b_t[0] ? {1'b0, a_t} : '0);
                        acc_t = {sum_t, acc_t[XLEN-1:1]};
                        b_t   = b_t >> 1;
                    end else begin
                        // restoring division: bring in next dividend bit, trial-subtract divisor
                        rem_t = {acc_t[2*XLEN-1:XLEN], a_t[XLEN-1]};
                        a_t   = a_t << 1;
                        qbit  = (rem_t >= {1'b0, b_t});
                        if (qbit)
                            rem_t = rem_t - {1'b0, b_t};
                        acc_t = {rem_t[XLEN-1:0], acc_t[XLEN-2:0], qbit};
                    end
                end
                acc_d = acc_t;
                a_d   = a_t;
                b_d   = b_t;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1))
                    state_d = FIX;
            end

            FIX: begin
                if (!funct_q[2]) begin
                    fix_t = neg_q ? (~acc_q + 1'b1) : acc_q;
                    res_d = (funct_q[1:0] == 2'b00) ? fix_t[XLEN-1:0] : fix_t[2*XLEN-1:XLEN];
                end else if (funct_q[1]) begin
                    res_d = neg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
                end else begin
                    res_d = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= IDLE;
            funct_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            funct_q <= funct_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            res_q   <= res_d;
        end
    end

    assign bus.oBusy   = busy_q;
    assign bus.oDone   = done_q;
    assign bus.oResult = res_q;
endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter: directed vector table, hand sequences, random ops vs reference model.
// Latency is measured in rising edges from the accepting edge to the edge raising oDone.
// Inputs are driven on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_muldiv_iter;
    parameter int STEP = 1;
    localparam int XLEN = 32;
    localparam int N    = XLEN / STEP;
    localparam int LDIV = N + 2;
`ifdef MULDIV_FAST_MUL_EN
    localparam int LMUL = 2;
`else
    localparam int LMUL = N + 2;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    muldiv_iter_if #(.XLEN(XLEN)) bus ();

    muldiv_iter #(.XLEN(XLEN), .STEP(STEP)) dut (
        .iCLK (clk),
        .iRST (rst),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model straight from the RV32M rules, using plain SV arithmetic.
    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic signed [63:0] ps;
        logic [63:0]        pu;
        logic               ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin pu = {32'd0, a} * {32'd0, b}; ref_res = pu[31:0]; end
            3'd1: begin ps = 64'(sa) * 64'(sb); ref_res = ps[63:32]; end
            3'd2: begin ps = 64'(sa) * $signed({32'd0, b}); ref_res = ps[63:32]; end
            3'd3: begin pu = {32'd0, a} * {32'd0, b}; ref_res = pu[63:32]; end
            3'd4: ref_res = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            3'd5: ref_res = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: ref_res = (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
            default: ref_res = (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0)) return 2;
        if (f[2] && !f[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 2;
        if (!f[2]) return LMUL;
        return LDIV;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: pick = 32'd0;
            1: pick = 32'h8000_0000;
            2: pick = 32'hFFFF_FFFF;
            3: pick = 32'($urandom_range(0, 15));
            4: pick = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            default: pick = $urandom;
        endcase
    endfunction

    // Issue one op and wait (bounded) for its oDone; scrambles operands after acceptance.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        bit busy_bad = 1'b0;
        @(negedge clk);
        bus.iStart = 1'b1; bus.iFunct3 = f; bus.iA = a; bus.iB = b;
        @(posedge clk); #1;
        chk("accept_busy", 64'(bus.oBusy), 64'd1);
        chk("accept_done", 64'(bus.oDone), 64'd0);
        bus.iStart = 1'b0; bus.iA = $urandom; bus.iB = $urandom; bus.iFunct3 = 3'($urandom);
        lat = 0;
        while (1) begin
            @(posedge clk); #1;
            lat++;
            if (bus.oDone) break;
            if (!bus.oBusy) busy_bad = 1'b1;
            if (lat >= 200) break;
        end
        chk("done_seen", 64'(bus.oDone), 64'd1);
        chk("busy_clear", 64'(bus.oBusy), 64'd0);
        chk("busy_hold", 64'(busy_bad), 64'd0);
        res = bus.oResult;
    endtask

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t        vt[16];
    logic [31:0] res;
    int          lat;
    int          dones;

    initial begin
        bus.iStart = 1'b0; bus.iFunct3 = '0; bus.iA = '0; bus.iB = '0;

        vt[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, LMUL};
        vt[1]  = '{3'd1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, LMUL};
        vt[2]  = '{3'd2, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, LMUL};
        vt[3]  = '{3'd3, 32'h8000_0000,  32'hFFFF_FFFF, 32'h7FFF_FFFF, LMUL};
        vt[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, LDIV};
        vt[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, LDIV};
        vt[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        LDIV};
        vt[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         LDIV};
        vt[8]  = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 2};
        vt[9]  = '{3'd7, 32'd5,          32'd0,         32'd5,         2};
        vt[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2};
        vt[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         2};
        vt[12] = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 2};
        vt[13] = '{3'd6, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB, 2};
        vt[14] = '{3'd0, 32'd6,          32'd7,         32'd42,        LMUL};
        vt[15] = '{3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1,         LDIV};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(bus.oBusy), 64'd0);
        chk("rst_done", 64'(bus.oDone), 64'd0);
        chk("rst_result", 64'(bus.oResult), 64'd0);
        @(negedge clk); rst = 1'b0;

        // directed table
        for (int i = 0; i < 16; i++) begin
            run_op(vt[i].f, vt[i].a, vt[i].b, res, lat);
            chk($sformatf("vec%0d_result", i), 64'(res), 64'(vt[i].exp));
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vt[i].lat));
        end

        // result register holds after completion
        repeat (3) @(posedge clk);
        #1;
        chk("result_hold", 64'(bus.oResult), 64'(vt[15].exp));
        chk("done_pulse", 64'(bus.oDone), 64'd0);

        // reset in the middle of an iterating divide (counter = 10)
        @(negedge clk);
        bus.iStart = 1'b1; bus.iFunct3 = 3'd5; bus.iA = 32'd1000; bus.iB = 32'd3;
        @(posedge clk); #1;
        bus.iStart = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_busy", 64'(bus.oBusy), 64'd0);
        chk("midrst_done", 64'(bus.oDone), 64'd0);
        chk("midrst_result", 64'(bus.oResult), 64'd0);
        @(negedge clk); rst = 1'b0;
        dones = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (bus.oDone) dones++;
        end
        chk("midrst_no_done", 64'(dones), 64'd0);
        run_op(3'd5, 32'd9, 32'd3, res, lat);
        chk("after_rst_divu", 64'(res), 64'd3);

        // back-to-back: next request driven during the oDone cycle
        run_op(3'd5, 32'd9, 32'd3, res, lat);
        chk("b2b_first", 64'(res), 64'd3);
        chk("b2b_first_lat", 64'(lat), 64'(LDIV));
        run_op(3'd0, 32'd6, 32'd7, res, lat);
        chk("b2b_second", 64'(res), 64'd42);
        chk("b2b_second_lat", 64'(lat), 64'(LMUL));

        // randomized ops against the reference model
        for (int i = 0; i < 150; i++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            run_op(f, a, b, res, lat);
            chk($sformatf("rnd%0d_f%0d_%h_%h", i, f, a, b), 64'(res), 64'(ref_res(f, a, b)));
            chk($sformatf("rnd%0d_lat", i), 64'(lat), 64'(ref_lat(f, a, b)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
